// File: rtl/conv_add_sequencer.sv
// conv_add_sequencer: issue sequencer for the conv adder-tree pipeline
// (mult -> Add1st -> Add2nd -> Add3rd). Walks every (cnt, pos) pair,
// drives the shared stage enable, tracks in-flight items with valid/last
// shift registers and honours downstream back-pressure on stall.
// Optional: define SEQ_STALL_CNT_EN to add the saturating stall_cycles counter.
module conv_add_sequencer #(
  parameter int CNT_NUM    = 32,
  parameter int POS_NUM    = 9,
  parameter int PIPE_DEPTH = 4,
  parameter int CNT_W      = 5,
  parameter int POS_W      = 4
) (
  input  logic             clk,
  input  logic             rst_b,
  input  logic             start,
  input  logic             stall,
  output logic             en,
  output logic [CNT_W-1:0] cnt_in,
  output logic [POS_W-1:0] pos_in,
  output logic             head_vld,
  output logic             tail_vld,
  output logic             tail_last,
  output logic             busy,
  output logic             done
`ifdef SEQ_STALL_CNT_EN
  ,
  output logic [15:0]      stall_cycles
`endif
);

  localparam logic [CNT_W-1:0] LP_CNT_LAST = CNT_W'(CNT_NUM - 1);
  localparam logic [POS_W-1:0] LP_POS_LAST = POS_W'(POS_NUM - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t                r_state;
  logic                  r_busy;
  logic                  r_done;
  logic [CNT_W-1:0]      r_cnt;
  logic [POS_W-1:0]      r_pos;
  logic [PIPE_DEPTH-1:0] r_vld;
  logic [PIPE_DEPTH-1:0] r_last;

  logic w_en;
  logic w_head_vld;
  logic w_final_pair;
  logic w_upper_vld;
  logic w_drain_done;

  assign w_final_pair = (r_cnt == LP_CNT_LAST) && (r_pos == LP_POS_LAST);
  assign w_head_vld   = (r_state == S_RUN) & ~stall;
  assign w_en         = r_busy & ~stall;

  // Any item still in stages 0..PIPE_DEPTH-2 (none exist when PIPE_DEPTH=1)
  always_comb begin
    w_upper_vld = 1'b0;
    for (int unsigned i = 0; i + 1 < PIPE_DEPTH; i++) begin
      w_upper_vld = w_upper_vld | r_vld[i];
    end
  end

  // Run is drained once the final item is leaving the tail un-stalled
  assign w_drain_done = ~w_upper_vld & r_vld[PIPE_DEPTH-1] &
                        r_last[PIPE_DEPTH-1] & ~stall;

  // Control FSM with pair counters and registered busy/done
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r_state <= S_IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_cnt   <= '0;
      r_pos   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state <= S_RUN;
            r_busy  <= 1'b1;
            r_cnt   <= '0;
            r_pos   <= '0;
          end
        end
        S_RUN: begin
          if (!stall) begin
            if (w_final_pair) begin
              r_state <= S_DRAIN;
            end else if (r_pos == LP_POS_LAST) begin
              r_pos <= '0;
              r_cnt <= r_cnt + CNT_W'(1);
            end else begin
              r_pos <= r_pos + POS_W'(1);
            end
          end
        end
        S_DRAIN: begin
          if (w_drain_done) begin
            r_state <= S_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_done  <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  // In-flight valid/last tracking; advances only with the stage enable
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r_vld  <= '0;
      r_last <= '0;
    end else if (w_en) begin
      for (int unsigned i = 1; i < PIPE_DEPTH; i++) begin
        r_vld[i]  <= r_vld[i-1];
        r_last[i] <= r_last[i-1];
      end
      r_vld[0]  <= w_head_vld;
      r_last[0] <= w_head_vld & w_final_pair;
    end
  end

`ifdef SEQ_STALL_CNT_EN
  logic [15:0] r_stall_cycles;

  // Saturating count of stalled busy cycles, cleared when a run is accepted
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r_stall_cycles <= '0;
    end else if ((r_state == S_IDLE) && start) begin
      r_stall_cycles <= '0;
    end else if (r_busy && stall && (r_stall_cycles != '1)) begin
      r_stall_cycles <= r_stall_cycles + 16'd1;
    end
  end

  assign stall_cycles = r_stall_cycles;
`endif

  assign en        = w_en;
  assign head_vld  = w_head_vld;
  assign cnt_in    = r_cnt;
  assign pos_in    = r_pos;
  assign tail_vld  = r_vld[PIPE_DEPTH-1];
  assign tail_last = r_last[PIPE_DEPTH-1];
  assign busy      = r_busy;
  assign done      = r_done;

endmodule

// File: tb/tb_conv_add_sequencer.sv
// Self-checking bench for conv_add_sequencer. A transaction-level model
// (issue index, enabled-cycle count, queue of in-flight items) predicts every
// output each cycle; a second small instance covers PIPE_DEPTH=1/POS_NUM=1.
module tb_conv_add_sequencer;
  localparam int CNT_NUM = 32;
  localparam int POS_NUM = 9;
  localparam int PD      = 4;
  localparam int N       = CNT_NUM * POS_NUM;
  localparam int S_CNT   = 4;

  logic clk = 1'b0;
  logic rst_b = 1'b0;
  logic start = 1'b0;
  logic stall = 1'b0;
  logic en, head_vld, tail_vld, tail_last, busy, done;
  logic [4:0] cnt_in;
  logic [3:0] pos_in;

  logic s_start = 1'b0;
  logic s_stall = 1'b0;
  logic s_en, s_head_vld, s_tail_vld, s_tail_last, s_busy, s_done;
  logic [1:0] s_cnt_in;
  logic [0:0] s_pos_in;
`ifdef SEQ_STALL_CNT_EN
  logic [15:0] stall_cycles;
  logic [15:0] s_stall_cycles;
`endif

  always #5 clk = ~clk;

  conv_add_sequencer #(
    .CNT_NUM(CNT_NUM), .POS_NUM(POS_NUM), .PIPE_DEPTH(PD), .CNT_W(5), .POS_W(4)
  ) dut (
    .clk(clk), .rst_b(rst_b), .start(start), .stall(stall), .en(en),
    .cnt_in(cnt_in), .pos_in(pos_in), .head_vld(head_vld), .tail_vld(tail_vld),
    .tail_last(tail_last), .busy(busy), .done(done)
`ifdef SEQ_STALL_CNT_EN
    , .stall_cycles(stall_cycles)
`endif
  );

  conv_add_sequencer #(
    .CNT_NUM(S_CNT), .POS_NUM(1), .PIPE_DEPTH(1), .CNT_W(2), .POS_W(1)
  ) dut_small (
    .clk(clk), .rst_b(rst_b), .start(s_start), .stall(s_stall), .en(s_en),
    .cnt_in(s_cnt_in), .pos_in(s_pos_in), .head_vld(s_head_vld), .tail_vld(s_tail_vld),
    .tail_last(s_tail_last), .busy(s_busy), .done(s_done)
`ifdef SEQ_STALL_CNT_EN
    , .stall_cycles(s_stall_cycles)
`endif
  );

  int n_total = 0;
  int n_bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model state
  typedef struct {
    int k;
    int t;
  } item_t;
  item_t m_q[$];
  bit m_active = 1'b0;
  bit m_done   = 1'b0;
  int m_issued = 0;
  int m_ecount = 0;
  int m_stalls = 0;
  int m_accepts = 0;

  int cyc = 0;
  int c0 = 0;
  int done_cyc = 0;
  bit got_done = 1'b0;
  int n_done_total = 0;
  int n_head = 0;

  bit small_on = 1'b0;
  bit s_prev_hv = 1'b0;
  int s_prev_cnt = 0;
  int s_nheads = 0;
  int s_c0 = 0;
  int s_done_cyc = 0;

  task automatic model_reset();
    m_active = 1'b0;
    m_done   = 1'b0;
    m_issued = 0;
    m_ecount = 0;
    m_stalls = 0;
    m_q.delete();
  endtask

  task automatic model_step();
    bit   exp_tail;
    int   tk;
    item_t it;
    exp_tail = (m_q.size() > 0) && (m_q[0].t + PD == m_ecount);
    tk = exp_tail ? m_q[0].k : -1;
    chk("busy", busy, m_active);
    chk("en", en, m_active && !stall);
    chk("head_vld", head_vld, m_active && (m_issued < N) && !stall);
    if (m_active && (m_issued < N)) begin
      chk("cnt_in", cnt_in, m_issued / POS_NUM);
      chk("pos_in", pos_in, m_issued % POS_NUM);
    end
    chk("tail_vld", tail_vld, exp_tail);
    chk("tail_last", tail_last, exp_tail && (tk == N - 1));
    chk("done", done, m_done);
`ifdef SEQ_STALL_CNT_EN
    chk("stall_cycles", stall_cycles, m_stalls);
`endif
    if (m_done) begin
      m_done = 1'b0;
    end else if (!m_active) begin
      if (start) begin
        m_active = 1'b1;
        m_issued = 0;
        m_ecount = 0;
        m_stalls = 0;
        m_q.delete();
        m_accepts++;
      end
    end else if (stall) begin
      if (m_stalls < 65535) m_stalls++;
    end else begin
      if (m_issued < N) begin
        it.k = m_issued;
        it.t = m_ecount;
        m_q.push_back(it);
        m_issued++;
      end
      if (exp_tail) begin
        void'(m_q.pop_front());
        if (tk == N - 1) begin
          m_active = 1'b0;
          m_done   = 1'b1;
        end
      end
      m_ecount++;
    end
  endtask

  // One clock cycle: inputs already driven; sample/check at negedge
  task automatic tick();
    @(negedge clk);
    cyc++;
    if (done) begin
      got_done = 1'b1;
      done_cyc = cyc;
      n_done_total++;
    end
    if (head_vld) n_head++;
    model_step();
    if (small_on) begin
      chk("s_tail_vld", s_tail_vld, s_prev_hv);
      chk("s_tail_last", s_tail_last, s_prev_hv && (s_prev_cnt == S_CNT - 1));
      if (s_head_vld) begin
        chk("s_cnt_order", s_cnt_in, s_nheads);
        s_nheads++;
      end
      if (s_done) s_done_cyc = cyc;
      s_prev_hv  = s_head_vld;
      s_prev_cnt = s_cnt_in;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic start_run();
    c0 = cyc + 1;
    got_done = 1'b0;
    n_head = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int i;
    i = 0;
    while (!got_done && i < budget) begin
      tick();
      i++;
    end
    chk(tag, got_done, 1'b1);
  endtask

  initial begin
    // Reset state
    #2;
    chk("rst_en", en, 1'b0);
    chk("rst_head", head_vld, 1'b0);
    chk("rst_tail", tail_vld, 1'b0);
    chk("rst_last", tail_last, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_cnt_pos", {cnt_in, pos_in}, 9'd0);
    tick();
    tick();
    rst_b = 1'b1;
    tick();

    // Reset mid-run at (3,5): run abandoned, no done pulse
    start_run();
    for (int i = 0; i < 200 && !(cnt_in == 5'd3 && pos_in == 4'd5); i++) tick();
    chk("reach_3_5", {cnt_in, pos_in}, {5'd3, 4'd5});
    rst_b = 1'b0;
    #2;
    chk("abort_busy", busy, 1'b0);
    chk("abort_head", head_vld, 1'b0);
    chk("abort_cnt_pos", {cnt_in, pos_in}, 9'd0);
    model_reset();
    tick();
    rst_b = 1'b1;
    tick();
    chk("no_done_abort", n_done_total, 0);

    // Unstalled full run: order, tail, timing
    start_run();
    wait_done("run1_timeout", 600);
    chk("run1_len", done_cyc - c0, N + PD + 1);
    chk("run1_heads", n_head, N);
    repeat (3) tick();

    // Stall 3 cycles at (10,4), then 2 cycles during drain
    start_run();
    for (int i = 0; i < 200 && !(cnt_in == 5'd10 && pos_in == 4'd4); i++) tick();
    chk("reach_10_4", {cnt_in, pos_in}, {5'd10, 4'd4});
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_en", en, 1'b0);
      chk("stall_hold", {cnt_in, pos_in}, {5'd10, 4'd4});
    end
    stall = 1'b0;
    for (int i = 0; i < 600 && m_issued < N; i++) tick();
    chk("final_issued", m_issued, N);
    stall = 1'b1;
    tick();
    tick();
    stall = 1'b0;
    wait_done("run2_timeout", 600);
    chk("run2_len", done_cyc - c0, N + PD + 1 + 5);
    chk("run2_heads", n_head, N);
`ifdef SEQ_STALL_CNT_EN
    chk("stall_cnt_at_done", stall_cycles, 16'd5);
`endif

    // start pulses during RUN and DONE are ignored
    start_run();
`ifdef SEQ_STALL_CNT_EN
    chk("stall_cnt_clear", stall_cycles, 16'd0);
`endif
    for (int i = 0; i < 40; i++) begin
      start = (i % 7 == 3);
      tick();
    end
    start = 1'b0;
    for (int i = 0; i < 600 && !m_done; i++) tick();
    chk("reach_done", m_done, 1'b1);
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    chk("run3_one_done", got_done, 1'b1);
    chk("start_in_done_ignored", busy, 1'b0);

    // Randomized stall/start traffic, including stalls while idle
    for (int i = 0; i < 10; i++) begin
      stall = $urandom_range(0, 1);
      tick();
    end
    stall = 1'b0;
    start_run();
    for (int i = 0; i < 3000 && !got_done; i++) begin
      stall = ($urandom_range(0, 3) == 0);
      start = ($urandom_range(0, 15) == 0);
      tick();
    end
    stall = 1'b0;
    start = 1'b0;
    chk("rand_done", got_done, 1'b1);
    chk("rand_heads", n_head, N);
    repeat (3) tick();
    chk("done_per_start", n_done_total, m_accepts - 1);

    // PIPE_DEPTH=1, POS_NUM=1 instance
    small_on = 1'b1;
    s_c0 = cyc + 1;
    s_start = 1'b1;
    tick();
    s_start = 1'b0;
    for (int i = 0; i < 20; i++) tick();
    small_on = 1'b0;
    chk("s_heads", s_nheads, S_CNT);
    chk("s_run_len", s_done_cyc - s_c0, S_CNT + 2);
`ifdef SEQ_STALL_CNT_EN
    chk("s_stall_cycles", s_stall_cycles, 16'd0);
`endif

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
